// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the request and bus signals that connect mem_arbiter to the fetch
//   stage, the memory stage and the external single-port memory bus.
//
//   Handshake: the fetch and data requesters raise x_req and hold their
//   address/data stable until x_gnt. On the bus side, bus_valid and its payload
//   stay stable until the cycle in which bus_ready is high. That cycle completes
//   the transfer. bus_rdata is only meaningful in that cycle.
//
//   Modports:
//     master - the arbiter: drives grants, read data, stalls, bus request, bus_err
//     slave  - the environment: drives requests, bus_ready, bus_rdata
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic [31:0] dm_rdata;

  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  logic        stall_f;
  logic        stall_m;
  logic        bus_err;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, bus_ready, bus_rdata,
    output if_gnt, if_rdata, dm_gnt, dm_rdata, bus_valid, bus_we, bus_addr,
           bus_wdata, stall_f, stall_m, bus_err
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, bus_ready, bus_rdata,
    input  if_gnt, if_rdata, dm_gnt, dm_rdata, bus_valid, bus_we, bus_addr,
           bus_wdata, stall_f, stall_m, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Serializes instruction fetches and data loads/stores onto one memory bus.
//   Data requests win by default. After STARVE_LIMIT consecutive data grants
//   with a fetch waiting, the fetch is forced through.
//
//   Ports:
//     clk            - clock
//     rst            - synchronous, active-low reset
//     bus_if         - mem_arbiter_if.master: requests, grants, bus, stalls, bus_err
//     dbg_state      - current FSM state (0 IDLE, 1 BUSY_I, 2 BUSY_D)
//     dbg_starve_cnt - current starvation counter value
//
//   Optional feature: define ARB_TIMEOUT_EN to abort a transfer after TIMEOUT
//   wait cycles. An abort returns to IDLE, pulses bus_err and issues no grant.
//   Without this macro, bus_err is tied to 0 and the arbiter waits for
//   bus_ready indefinitely.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus_if,
  output logic [1:0]    dbg_state,
  output logic [2:0]    dbg_starve_cnt
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
    $error("mem_arbiter: STARVE_LIMIT must fit the 3-bit counter (1..7)");
  end
  if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must fit the 5-bit wait counter (1..31)");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  state_t      state_q;
  logic        bus_valid_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [2:0]  starve_q;

  logic done_i;
  logic done_d;
  logic pick_i;
  logic abort;

  // A transfer completes in the bus_ready cycle. The grant is gated by rst so
  // that a transfer aborted by reset never reports completion.
  assign done_i = rst && (state_q == BUSY_I) && bus_if.bus_ready;
  assign done_d = rst && (state_q == BUSY_D) && bus_if.bus_ready;

  // Fetch wins from IDLE only when it is alone or has been starved long enough.
  assign pick_i = bus_if.if_req && (!bus_if.dm_req || (starve_q == STARVE_MAX));

`ifdef ARB_TIMEOUT_EN
  logic [4:0] wait_q;
  logic       bus_err_q;

  // Abort on the edge where the wait count would reach TIMEOUT. bus_err then
  // shows in the first IDLE cycle after the abort.
  assign abort = (state_q != IDLE) && !bus_if.bus_ready && (wait_q == 5'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= abort;
      if (state_q == IDLE || abort || bus_if.bus_ready) begin
        wait_q <= '0;
      end else begin
        wait_q <= wait_q + 5'd1;
      end
    end
  end

  assign bus_if.bus_err = bus_err_q;
`else
  assign abort          = 1'b0;
  assign bus_if.bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      starve_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus_if.if_req) begin
            starve_q <= '0;
          end
          if (bus_if.if_req || bus_if.dm_req) begin
            bus_valid_q <= 1'b1;
            if (pick_i) begin
              state_q     <= BUSY_I;
              bus_we_q    <= 1'b0;
              bus_addr_q  <= bus_if.if_addr;
              bus_wdata_q <= '0;
            end else begin
              state_q     <= BUSY_D;
              bus_we_q    <= bus_if.dm_we;
              bus_addr_q  <= bus_if.dm_addr;
              bus_wdata_q <= bus_if.dm_wdata;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus_if.bus_ready || abort) begin
            state_q     <= IDLE;
            bus_valid_q <= 1'b0;
          end
          if (done_i) begin
            starve_q <= '0;
          end else if (done_d && bus_if.if_req && (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + 3'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          bus_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.bus_valid = bus_valid_q;
  assign bus_if.bus_we    = bus_we_q;
  assign bus_if.bus_addr  = bus_addr_q;
  assign bus_if.bus_wdata = bus_wdata_q;

  assign bus_if.if_gnt   = done_i;
  assign bus_if.dm_gnt   = done_d;
  assign bus_if.if_rdata = done_i ? bus_if.bus_rdata : 32'h0;
  assign bus_if.dm_rdata = done_d ? bus_if.bus_rdata : 32'h0;

  assign bus_if.stall_f = bus_if.if_req && !done_i;
  assign bus_if.stall_m = bus_if.dm_req && !done_d;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Inputs are driven 1 time unit after the
//   rising edge, and outputs are sampled on the falling edge.
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [2:0] dbg_starve_cnt;

  mem_arbiter_if bus_if ();

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT     (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_if        (bus_if),
    .dbg_state     (dbg_state),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_if.if_req    = 1'b0;
    bus_if.if_addr   = '0;
    bus_if.dm_req    = 1'b0;
    bus_if.dm_we     = 1'b0;
    bus_if.dm_addr   = '0;
    bus_if.dm_wdata  = '0;
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = '0;
  endtask

  logic [31:0] got;
  logic [31:0] want;
  logic        chk_starve_zero;

  initial begin
    // ---------- reset with both requests high ----------
    idle_inputs();
    rst              = 1'b0;
    bus_if.if_req    = 1'b1;
    bus_if.if_addr   = 32'h0000_0044;
    bus_if.dm_req    = 1'b1;
    bus_if.dm_addr   = 32'h0000_0088;
    bus_if.bus_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      settle();
      check("rst_bus_valid", 32'(bus_if.bus_valid), 0);
      check("rst_if_gnt", 32'(bus_if.if_gnt), 0);
      check("rst_dm_gnt", 32'(bus_if.dm_gnt), 0);
      check("rst_stall_f", 32'(bus_if.stall_f), 1);
      check("rst_stall_m", 32'(bus_if.stall_m), 1);
      check("rst_bus_err", 32'(bus_if.bus_err), 0);
      next_cycle();
    end
    rst = 1'b1;
    idle_inputs();
    bus_if.bus_ready = 1'b1;   // stray bus_ready while IDLE
    settle();
    check("rst_state_idle", 32'(dbg_state), 0);
    check("rst_bus_addr", bus_if.bus_addr, 0);
    check("rst_starve", 32'(dbg_starve_cnt), 0);
    check("idle_ready_no_if_gnt", 32'(bus_if.if_gnt), 0);
    check("idle_ready_no_dm_gnt", 32'(bus_if.dm_gnt), 0);

    // ---------- single fetch, zero wait states ----------
    next_cycle();   // cycle 0
    bus_if.bus_ready = 1'b0;
    bus_if.if_req    = 1'b1;
    bus_if.if_addr   = 32'h0000_0010;
    settle();
    check("fetch_c0_valid", 32'(bus_if.bus_valid), 0);
    check("fetch_c0_stall_f", 32'(bus_if.stall_f), 1);
    next_cycle();   // cycle 1
    bus_if.bus_ready = 1'b1;
    bus_if.bus_rdata = 32'h0050_0093;
    settle();
    check("fetch_c1_valid", 32'(bus_if.bus_valid), 1);
    check("fetch_c1_addr", bus_if.bus_addr, 32'h0000_0010);
    check("fetch_c1_we", 32'(bus_if.bus_we), 0);
    check("fetch_c1_if_gnt", 32'(bus_if.if_gnt), 1);
    check("fetch_c1_if_rdata", bus_if.if_rdata, 32'h0050_0093);
    check("fetch_c1_stall_f", 32'(bus_if.stall_f), 0);
    check("fetch_c1_dm_gnt", 32'(bus_if.dm_gnt), 0);
    check("fetch_c1_dm_rdata", bus_if.dm_rdata, 0);
    next_cycle();   // cycle 2
    idle_inputs();
    settle();
    check("fetch_c2_valid", 32'(bus_if.bus_valid), 0);
    check("fetch_c2_if_rdata", bus_if.if_rdata, 0);

    // ---------- store with wait states, bus_ready at cycle 4 ----------
    next_cycle();   // cycle 0
    bus_if.dm_req    = 1'b1;
    bus_if.dm_we     = 1'b1;
    bus_if.dm_addr   = 32'h0000_0100;
    bus_if.dm_wdata  = 32'hDEAD_BEEF;
    bus_if.bus_rdata = 32'h1234_5678;
    settle();
    check("store_c0_stall_m", 32'(bus_if.stall_m), 1);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      bus_if.bus_ready = (c == 4);
      settle();
      check("store_valid", 32'(bus_if.bus_valid), 1);
      check("store_addr", bus_if.bus_addr, 32'h0000_0100);
      check("store_we", 32'(bus_if.bus_we), 1);
      check("store_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);
      check("store_dm_gnt", 32'(bus_if.dm_gnt), (c == 4) ? 32'd1 : 32'd0);
      check("store_stall_m", 32'(bus_if.stall_m), (c == 4) ? 32'd0 : 32'd1);
      check("store_dm_rdata", bus_if.dm_rdata, (c == 4) ? 32'h1234_5678 : 32'h0);
    end
    next_cycle();   // cycle 5
    idle_inputs();
    settle();
    check("store_c5_valid", 32'(bus_if.bus_valid), 0);

    // ---------- priority and starvation ----------
    next_cycle();
    bus_if.if_req   = 1'b1;
    bus_if.if_addr  = 32'h0000_0200;
    bus_if.dm_req   = 1'b1;
    bus_if.dm_we    = 1'b0;
    bus_if.dm_addr  = 32'h0000_0300;
    bus_if.dm_wdata = 32'h1111_1111;
    // 1 = data grant, 2 = fetch grant
    exp_q = {};
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd1);
    chk_starve_zero = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus_if.bus_ready = bus_if.bus_valid;
      bus_if.bus_rdata = 32'h0000_1000 + 32'(c);
      settle();
      if (chk_starve_zero) begin
        check("starve_cleared", 32'(dbg_starve_cnt), 0);
        chk_starve_zero = 1'b0;
      end
      if (bus_if.if_gnt || bus_if.dm_gnt) begin
        check("one_grant_only", 32'(bus_if.if_gnt && bus_if.dm_gnt), 0);
        got  = bus_if.if_gnt ? 32'd2 : 32'd1;
        want = exp_q.pop_front();
        check("grant_order", got, want);
        check("grant_addr", bus_if.bus_addr, (got == 32'd2) ? 32'h0000_0200 : 32'h0000_0300);
        if (got == 32'd2) begin
          check("fetch_rdata", bus_if.if_rdata, 32'h0000_1000 + 32'(c));
          check("starve_at_limit", 32'(dbg_starve_cnt), 4);
          chk_starve_zero = 1'b1;
        end else begin
          check("load_rdata", bus_if.dm_rdata, 32'h0000_1000 + 32'(c));
        end
      end
      if (exp_q.size() == 0) break;
      next_cycle();
    end
    check("starve_all_grants_seen", 32'(exp_q.size()), 0);
    next_cycle();
    idle_inputs();
    settle();
    check("starve_end_valid", 32'(bus_if.bus_valid), 0);

    // ---------- reset in the middle of a load ----------
    next_cycle();   // cycle 0
    bus_if.dm_req  = 1'b1;
    bus_if.dm_we   = 1'b0;
    bus_if.dm_addr = 32'h0000_0400;
    settle();
    check("mid_c0_stall_m", 32'(bus_if.stall_m), 1);
    next_cycle();   // cycle 1
    settle();
    check("mid_c1_valid", 32'(bus_if.bus_valid), 1);
    next_cycle();   // cycle 2
    rst = 1'b0;
    settle();
    check("mid_c2_dm_gnt", 32'(bus_if.dm_gnt), 0);
    check("mid_c2_stall_m", 32'(bus_if.stall_m), 1);
    next_cycle();   // cycle 3
    rst = 1'b1;
    settle();
    check("mid_c3_valid", 32'(bus_if.bus_valid), 0);
    check("mid_c3_state", 32'(dbg_state), 0);
    check("mid_c3_dm_gnt", 32'(bus_if.dm_gnt), 0);
    next_cycle();   // cycle 4: request reissued from IDLE
    bus_if.bus_ready = 1'b1;
    bus_if.bus_rdata = 32'hCAFE_F00D;
    settle();
    check("mid_c4_valid", 32'(bus_if.bus_valid), 1);
    check("mid_c4_addr", bus_if.bus_addr, 32'h0000_0400);
    check("mid_c4_dm_gnt", 32'(bus_if.dm_gnt), 1);
    check("mid_c4_dm_rdata", bus_if.dm_rdata, 32'hCAFE_F00D);
    next_cycle();
    idle_inputs();
    settle();
    check("mid_c5_valid", 32'(bus_if.bus_valid), 0);
    check("mid_c5_bus_err", 32'(bus_if.bus_err), 0);

`ifdef ARB_TIMEOUT_EN
    // ---------- timeout: bus_ready never arrives ----------
    next_cycle();   // cycle 0
    bus_if.if_req  = 1'b1;
    bus_if.if_addr = 32'h0000_0500;
    settle();
    for (int c = 1; c <= 17; c++) begin
      next_cycle();
      settle();
      check("to_if_gnt", 32'(bus_if.if_gnt), 0);
      check("to_bus_err", 32'(bus_if.bus_err), (c == 17) ? 32'd1 : 32'd0);
      check("to_valid", 32'(bus_if.bus_valid), (c == 17) ? 32'd0 : 32'd1);
    end
    next_cycle();   // cycle 18: held fetch accepted again
    bus_if.bus_ready = 1'b1;
    bus_if.bus_rdata = 32'h0000_0013;
    settle();
    check("to_c18_bus_err", 32'(bus_if.bus_err), 0);
    check("to_c18_valid", 32'(bus_if.bus_valid), 1);
    check("to_c18_if_gnt", 32'(bus_if.if_gnt), 1);
    check("to_c18_if_rdata", bus_if.if_rdata, 32'h0000_0013);
    next_cycle();
    idle_inputs();
    settle();
`endif

    // ---------- report ----------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #20000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
